ram_cpu_access_ctrl: RTL and testbench

// - Load/store controller directly upstream of the 32-bit dual-port RAM_CPU data memory.
// - Accepts one CPU byte/half/word request at a time and drives the RAM rdaddress/wraddress/wren/data/aclr inputs.
// - Captures RAM q and returns extended load data; sub-word stores use read-modify-write (RAM has no byte enables).

---
 rtl/ram_cpu_access_ctrl.sv | 147 ++++++++++++++
 tb/tb_ram_cpu_access_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_cpu_access_ctrl.sv
// Load/store controller in front of the 32-bit dual-port RAM_CPU memory.
// Sub-word stores use read-modify-write. Define RAM_CPU_MISALIGN_TRAP_EN to reject misaligned half/word requests.
module ram_cpu_access_ctrl #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clock,
  input  logic              sclr_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W+1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] ram_rdaddress,
  output logic [ADDR_W-1:0] ram_wraddress,
  output logic              ram_wren,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_aclr,
  input  logic [DATA_W-1:0] ram_q
);

  typedef enum logic [1:0] {IDLE, RD_WAIT, WRITE, RESP} state_e;

  localparam logic [1:0] RdWaitInit = 2'(RD_LAT);

  state_e            state_q;
  logic [1:0]        cnt_q;
  logic              we_q;
  logic              signed_q;
  logic [1:0]        size_q;
  logic [1:0]        lane_q;
  logic [15:0]       wdata_q;
  logic [ADDR_W-1:0] addr_q;
  logic              rsp_valid_q;
  logic              rsp_err_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic              ram_wren_q;
  logic [DATA_W-1:0] ram_data_q;
  logic [DATA_W-1:0] merge_d;
  logic [DATA_W-1:0] extend_d;

  assign req_ready     = (state_q == IDLE);
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_err       = rsp_err_q;
  assign ram_rdaddress = addr_q;
  assign ram_wraddress = addr_q;
  assign ram_wren      = ram_wren_q;
  assign ram_data      = ram_data_q;
  assign ram_aclr      = 1'b0;

  // Lane handling works on the word captured from RAM; size 11 behaves as a full word.
  always_comb begin
    merge_d  = ram_q;
    extend_d = ram_q;
    if (size_q == 2'b00) begin
      merge_d[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
      extend_d = {{24{signed_q & ram_q[{lane_q, 3'b111}]}}, ram_q[{lane_q, 3'b000} +: 8]};
    end else if (size_q == 2'b01) begin
      merge_d[{lane_q[1], 4'h0} +: 16] = wdata_q;
      extend_d = {{16{signed_q & ram_q[{lane_q[1], 4'hF}]}}, ram_q[{lane_q[1], 4'h0} +: 16]};
    end
  end

  always_ff @(posedge clock) begin
    if (!sclr_n) begin
      state_q     <= IDLE;
      cnt_q       <= 2'd0;
      we_q        <= 1'b0;
      signed_q    <= 1'b0;
      size_q      <= 2'b00;
      lane_q      <= 2'b00;
      wdata_q     <= 16'h0;
      addr_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      ram_wren_q  <= 1'b0;
      ram_data_q  <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      ram_wren_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            we_q     <= req_we;
            signed_q <= req_signed;
            size_q   <= req_size;
            lane_q   <= req_addr[1:0];
            wdata_q  <= req_wdata[15:0];
            addr_q   <= req_addr[ADDR_W+1:2];
            cnt_q    <= RdWaitInit;
`ifdef RAM_CPU_MISALIGN_TRAP_EN
            if ((req_size == 2'b01 && req_addr[0]) ||
                (req_size[1] && req_addr[1:0] != 2'b00)) begin
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= '0;
              state_q     <= RESP;
            end else
`endif
            if (req_we && req_size[1]) begin
              ram_data_q <= req_wdata;
              ram_wren_q <= 1'b1;
              state_q    <= WRITE;
            end else begin
              state_q <= RD_WAIT;
            end
          end
        end
        RD_WAIT: begin
          if (cnt_q == 2'd0) begin
            if (we_q) begin
              ram_data_q <= merge_d;
              ram_wren_q <= 1'b1;
              state_q    <= WRITE;
            end else begin
              rsp_rdata_q <= extend_d;
              rsp_err_q   <= 1'b0;
              rsp_valid_q <= 1'b1;
              state_q     <= RESP;
            end
          end else begin
            cnt_q <= cnt_q - 2'd1;
          end
        end
        WRITE: begin
          rsp_rdata_q <= '0;
          rsp_err_q   <= 1'b0;
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_cpu_access_ctrl.sv
// Scoreboard bench for ram_cpu_access_ctrl: a RAM_CPU model, a word-array reference model,
// and monitors that check response and write timing/content against expected queues.
module tb_ram_cpu_access_ctrl;

  localparam int AW    = 10;
  localparam int RdLat = 2;

  typedef struct {
    int          cyc;
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  typedef struct {
    int          cyc;
    logic [9:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic          clock;
  logic          sclr_n;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [1:0]    req_size;
  logic          req_signed;
  logic [AW+1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          rsp_valid;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;
  logic [AW-1:0] ram_rdaddress;
  logic [AW-1:0] ram_wraddress;
  logic          ram_wren;
  logic [31:0]   ram_data;
  logic          ram_aclr;
  logic [31:0]   ram_q;

  logic [31:0]   ramMem [0:1023];
  logic [AW-1:0] rdPipe [0:RdLat-1];
  logic          preload;
  logic [31:0]   refMem [0:1023];
  rsp_t          rspQ[$];
  wr_t           wrQ[$];
  int            cycleCnt;
  int            wrenCount;
  int            nTests;
  int            nFail;

  ram_cpu_access_ctrl #(.ADDR_W(AW), .DATA_W(32), .RD_LAT(RdLat)) dut (
    .clock(clock), .sclr_n(sclr_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .ram_rdaddress(ram_rdaddress), .ram_wraddress(ram_wraddress),
    .ram_wren(ram_wren), .ram_data(ram_data), .ram_aclr(ram_aclr), .ram_q(ram_q)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] initWord(input int i);
    return 32'(i) * 32'h9E37_79B9 + 32'h0123_4567;
  endfunction

  // RAM_CPU model: address registered at the edge, q valid RdLat cycles later.
  always @(posedge clock) begin
    if (preload) begin
      for (int i = 0; i < 1024; i++) ramMem[i] <= initWord(i);
    end else if (ram_wren === 1'b1) begin
      ramMem[ram_wraddress] <= ram_data;
    end
    rdPipe[0] <= ram_rdaddress;
    for (int i = 1; i < RdLat; i++) rdPipe[i] <= rdPipe[i-1];
  end
  assign ram_q = ramMem[rdPipe[RdLat-1]];

  always @(posedge clock) cycleCnt <= cycleCnt + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cycleCnt);
    end
  endtask

  always @(negedge clock) begin
    rsp_t e;
    wr_t  w;
    if (rsp_valid === 1'b1) begin
      if (rspQ.size() == 0) begin
        checkOutput("rsp_unexpected", 32'd1, 32'd0);
      end else begin
        e = rspQ.pop_front();
        checkOutput("rsp_cycle", 32'(cycleCnt), 32'(e.cyc));
        checkOutput("rsp_rdata", rsp_rdata, e.rdata);
        checkOutput("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
        checkOutput("ram_aclr", {31'd0, ram_aclr}, 32'd0);
      end
    end
    if (ram_wren === 1'b1) begin
      wrenCount++;
      if (wrQ.size() == 0) begin
        checkOutput("wren_unexpected", 32'd1, 32'd0);
      end else begin
        w = wrQ.pop_front();
        checkOutput("wren_cycle", 32'(cycleCnt), 32'(w.cyc));
        checkOutput("wr_address", {22'd0, ram_wraddress}, {22'd0, w.addr});
        checkOutput("wr_data", ram_data, w.data);
      end
    end
  end

  // Reference model: predicts response/write content and the cycle each appears in.
  function automatic void modelPush(input logic we, input logic [1:0] size, input logic sgn,
                                    input logic [11:0] addr, input logic [31:0] wdata,
                                    input int acc);
    logic [9:0]  wa;
    logic [31:0] mask;
    logic [31:0] old;
    logic [31:0] v;
    int          sh;
    rsp_t        r;
    wr_t         w;
    wa = addr[11:2];
`ifdef RAM_CPU_MISALIGN_TRAP_EN
    if ((size == 2'b01 && addr[0]) || (size[1] && addr[1:0] != 2'b00)) begin
      r.cyc = acc; r.rdata = 32'd0; r.err = 1'b1;
      rspQ.push_back(r);
      return;
    end
`endif
    if (size[1]) begin
      mask = 32'hFFFF_FFFF; sh = 0;
    end else if (size[0]) begin
      mask = 32'h0000_FFFF; sh = addr[1] ? 16 : 0;
    end else begin
      mask = 32'h0000_00FF; sh = 8 * int'(addr[1:0]);
    end
    old   = refMem[wa];
    r.err = 1'b0;
    if (we) begin
      if (size[1]) begin
        refMem[wa] = wdata;
        w.cyc = acc; r.cyc = acc + 1;
      end else begin
        refMem[wa] = (old & ~(mask << sh)) | ((wdata & mask) << sh);
        w.cyc = acc + RdLat + 1; r.cyc = acc + RdLat + 2;
      end
      w.addr  = wa;
      w.data  = refMem[wa];
      r.rdata = 32'd0;
      wrQ.push_back(w);
    end else begin
      v = (old >> sh) & mask;
      if (sgn && !size[1] && ((v & ((mask >> 1) + 1)) != 0)) v = v | ~mask;
      r.rdata = v;
      r.cyc   = acc + RdLat + 1;
    end
    rspQ.push_back(r);
  endfunction

  // Waits for IDLE (toggling junk requests meanwhile), then issues one request.
  task automatic applyStimulus(input logic we, input logic [1:0] size, input logic sgn,
                               input logic [11:0] addr, input logic [31:0] wdata);
    int waitCnt;
    waitCnt = 0;
    while (req_ready !== 1'b1 && waitCnt < 64) begin
      req_valid  = 1'($urandom_range(0, 1));
      req_we     = 1'($urandom);
      req_size   = 2'($urandom);
      req_signed = 1'($urandom);
      req_addr   = 12'($urandom);
      req_wdata  = $urandom;
      @(negedge clock);
      waitCnt++;
    end
    if (req_ready !== 1'b1) begin
      checkOutput("ready_timeout", {31'd0, req_ready}, 32'd1);
      req_valid = 1'b0;
      return;
    end
    req_valid  = 1'b1;
    req_we     = we;
    req_size   = size;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wdata;
    modelPush(we, size, sgn, addr, wdata, cycleCnt + 1);
    @(negedge clock);
    req_valid = 1'b0;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
    checkOutput({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
    checkOutput({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
    checkOutput({tag, "_rsp_err"}, {31'd0, rsp_err}, 32'd0);
    checkOutput({tag, "_ram_wren"}, {31'd0, ram_wren}, 32'd0);
    checkOutput({tag, "_ram_data"}, ram_data, 32'd0);
    checkOutput({tag, "_ram_rdaddress"}, {22'd0, ram_rdaddress}, 32'd0);
    checkOutput({tag, "_ram_wraddress"}, {22'd0, ram_wraddress}, 32'd0);
    checkOutput({tag, "_ram_aclr"}, {31'd0, ram_aclr}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] saved;
    int          wrenBefore;
    int          n;
    nTests = 0; nFail = 0; cycleCnt = 0; wrenCount = 0;
    preload = 1'b1; sclr_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_signed = 1'b0;
    req_addr = '0; req_wdata = '0;
    for (int i = 0; i < RdLat; i++) rdPipe[i] = '0;
    for (int i = 0; i < 1024; i++) refMem[i] = initWord(i);
    repeat (3) @(negedge clock);
    preload = 1'b0;
    checkResetState("reset");
    sclr_n = 1'b1;
    @(negedge clock);

    applyStimulus(1'b1, 2'b10, 1'b0, 12'h010, 32'hDEAD_BEEF);
    applyStimulus(1'b0, 2'b10, 1'b0, 12'h010, 32'h0);
    applyStimulus(1'b1, 2'b00, 1'b0, 12'h013, 32'h0000_0080);
    applyStimulus(1'b0, 2'b00, 1'b1, 12'h013, 32'h0);
    applyStimulus(1'b0, 2'b00, 1'b0, 12'h013, 32'h0);
    applyStimulus(1'b1, 2'b01, 1'b0, 12'h012, 32'h0000_A234);
    applyStimulus(1'b0, 2'b01, 1'b1, 12'h012, 32'h0);
    applyStimulus(1'b0, 2'b00, 1'b0, 12'h010, 32'h0);

    // Reset while a byte store is still waiting for its read: the write must never land.
    saved      = refMem[4];
    wrenBefore = wrenCount;
    applyStimulus(1'b1, 2'b00, 1'b0, 12'h010, 32'h0000_0055);
    sclr_n = 1'b0;
    rspQ.delete();
    wrQ.delete();
    refMem[4] = saved;
    repeat (2) @(negedge clock);
    sclr_n = 1'b1;
    checkResetState("midreset");
    repeat (RdLat + 4) @(negedge clock);
    checkOutput("no_wren_after_reset", 32'(wrenCount), 32'(wrenBefore));

    applyStimulus(1'b0, 2'b10, 1'b0, 12'h010, 32'h0);
    applyStimulus(1'b0, 2'b10, 1'b0, 12'h011, 32'h0);
    applyStimulus(1'b0, 2'b01, 1'b1, 12'h013, 32'h0);
    applyStimulus(1'b1, 2'b11, 1'b0, 12'h01C, 32'h1357_9BDF);
    applyStimulus(1'b0, 2'b11, 1'b1, 12'h01C, 32'h0);

    for (int k = 0; k < 250; k++) begin
      applyStimulus(1'($urandom), 2'($urandom), 1'($urandom),
                    {4'd0, 3'($urandom_range(0, 7)), 3'd0, 2'($urandom)}, $urandom);
      repeat ($urandom_range(0, 2)) @(negedge clock);
    end

    n = 0;
    while ((rspQ.size() != 0 || wrQ.size() != 0) && n < 100) begin
      @(negedge clock);
      n++;
    end
    checkOutput("rsp_queue_drained", 32'(rspQ.size()), 32'd0);
    checkOutput("wr_queue_drained", 32'(wrQ.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
